// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, ALU control codes, MIPS opcode and
// funct encodings, and an immediate sign-extension helper.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // ALU control code driven into the EX-stage ALU.
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_NAND = 3'b100,
        ALU_SLL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctrl_e;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0]).
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NAND = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decode/issue stage and its surroundings.
//   master : pipeline side (fetch, register file, later stages) - drives
//            the instruction, operands, forwarding candidates, flush, out_ready.
//   slave  : id_ex_stage - drives in_ready and all issued ALU/control outputs.
interface id_ex_stage_if
    import cpu_pkg::*;
();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] ex_result;
    logic            exmem_wr;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_wr;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [5:0]      alu_shamt;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] store_data;
    logic [4:0]      dest_rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, rs_data, rt_data, ex_result,
               exmem_wr, exmem_rd, exmem_result,
               memwb_wr, memwb_rd, memwb_result, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_shamt, alu_control,
               store_data, dest_rd, reg_write, mem_read, mem_write,
               branch, illegal
    );

    modport slave (
        input  flush, in_valid, instr, rs_data, rt_data, ex_result,
               exmem_wr, exmem_rd, exmem_result,
               memwb_wr, memwb_rd, memwb_result, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_shamt, alu_control,
               store_data, dest_rd, reg_write, mem_read, mem_write,
               branch, illegal
    );

endinterface

// File: rtl/id_decode.sv
// Combinational MIPS instruction decoder shared with the single-cycle datapath.
// Ports:
//   instr       in  32  instruction word
//   rs_idx      out 5   source register 1 field
//   rt_idx      out 5   source register 2 field
//   alu_shamt   out 6   {1'b0, instr[10:6]}
//   alu_control out 3   ALU operation
//   imm         out 32  extended immediate (sign or zero per opcode)
//   use_imm     out 1   ALU operand B takes imm instead of rt
//   dest_rd     out 5   destination register (0 when nothing is written)
//   reg_write, mem_read, mem_write, branch, illegal  out 1  control flags
module id_decode
    import cpu_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [4:0]      rs_idx,
    output logic [4:0]      rt_idx,
    output logic [5:0]      alu_shamt,
    output alu_ctrl_e       alu_control,
    output logic [XLEN-1:0] imm,
    output logic            use_imm,
    output logic [4:0]      dest_rd,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            illegal
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd_sel;
    logic       wr_en;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign rs_idx    = instr[25:21];
    assign rt_idx    = instr[20:16];
    assign alu_shamt = {1'b0, instr[10:6]};

    always_comb begin
        alu_control = ALU_ADD;
        imm         = sext16(instr[15:0]);
        use_imm     = 1'b0;
        rd_sel      = '0;
        wr_en       = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rd_sel = instr[15:11];
                wr_en  = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_XOR:  alu_control = ALU_XOR;
                    FN_NAND: alu_control = ALU_NAND;
                    FN_SLT:  alu_control = ALU_SLT;
                    FN_SLL:  alu_control = ALU_SLL;
                    default: begin
                        illegal = 1'b1;
                        rd_sel  = '0;
                        wr_en   = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI: begin
                alu_control = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                use_imm     = 1'b1;
                rd_sel      = instr[20:16];
                wr_en       = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_control = (opcode == OP_ANDI) ? ALU_AND :
                              (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
                imm         = {{(XLEN-16){1'b0}}, instr[15:0]};
                use_imm     = 1'b1;
                rd_sel      = instr[20:16];
                wr_en       = 1'b1;
            end
            OP_LW: begin
                use_imm  = 1'b1;
                rd_sel   = instr[20:16];
                wr_en    = 1'b1;
                mem_read = 1'b1;
            end
            OP_SW: begin
                use_imm   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                alu_control = ALU_SUB;
                branch      = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign dest_rd   = rd_sel;
    // Writes to $0 are architecturally discarded, so never flag them.
    assign reg_write = wr_en & (rd_sel != '0);

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue register stage feeding the 32-bit ALU. Decodes one instruction
// per cycle, forwards operands from EX, EX/MEM and MEM/WB, stalls one cycle on
// a load-use hazard, and registers all ALU operands and control flags.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   pipe   slave side of id_ex_stage_if (handshakes, operands, forwarding
//          candidates, flush, and all registered issue outputs)
// Parameters:
//   XLEN   datapath width (only 32 supported)
//   FWD_EN 1 enables forwarding, 0 reads rs/rt only from the register file
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave pipe
);

    logic [4:0]      rs_idx, rt_idx, dec_rd;
    logic [5:0]      dec_shamt;
    alu_ctrl_e       dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_use_imm, dec_rw, dec_mr, dec_mw, dec_br, dec_ill;

    logic            out_valid_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q, store_q;
    logic [5:0]      shamt_q;
    logic [2:0]      ctrl_q;
    logic [4:0]      dest_q;
    logic            rw_q, mr_q, mw_q, br_q, ill_q;

    logic            advance, load_use, capture, ex_fwd_ok;
    logic [XLEN-1:0] rs_fwd, rt_fwd;

    id_decode u_decode (
        .instr       (pipe.instr),
        .rs_idx      (rs_idx),
        .rt_idx      (rt_idx),
        .alu_shamt   (dec_shamt),
        .alu_control (dec_ctrl),
        .imm         (dec_imm),
        .use_imm     (dec_use_imm),
        .dest_rd     (dec_rd),
        .reg_write   (dec_rw),
        .mem_read    (dec_mr),
        .mem_write   (dec_mw),
        .branch      (dec_br),
        .illegal     (dec_ill)
    );

    // Priority: EX > EX/MEM > MEM/WB > register file; $0 always reads zero.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_ok,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_val,
        input logic            em_wr,
        input logic [4:0]      em_rd,
        input logic [XLEN-1:0] em_val,
        input logic            mw_wr,
        input logic [4:0]      mw_rd,
        input logic [XLEN-1:0] mw_val
    );
        if (idx == '0)                        return '0;
        if (FWD_EN && ex_ok && ex_rd == idx)  return ex_val;
        if (FWD_EN && em_wr && em_rd == idx)  return em_val;
        if (FWD_EN && mw_wr && mw_rd == idx)  return mw_val;
        return rf_val;
    endfunction

    // A load in EX has no result yet, so it is excluded from EX forwarding
    // and instead triggers the load-use stall below.
    assign ex_fwd_ok = out_valid_q & rw_q & ~mr_q;

    assign rs_fwd = fwd(rs_idx, pipe.rs_data, ex_fwd_ok, dest_q, pipe.ex_result,
                        pipe.exmem_wr, pipe.exmem_rd, pipe.exmem_result,
                        pipe.memwb_wr, pipe.memwb_rd, pipe.memwb_result);
    assign rt_fwd = fwd(rt_idx, pipe.rt_data, ex_fwd_ok, dest_q, pipe.ex_result,
                        pipe.exmem_wr, pipe.exmem_rd, pipe.exmem_result,
                        pipe.memwb_wr, pipe.memwb_rd, pipe.memwb_result);

    assign advance  = ~out_valid_q | pipe.out_ready;
    assign load_use = out_valid_q & mr_q & (dest_q != '0) &
                      ((dest_q == rs_idx) | (dest_q == rt_idx));
    assign pipe.in_ready = pipe.flush | (advance & ~load_use);
    assign capture  = pipe.in_valid & pipe.in_ready & ~pipe.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            store_q     <= '0;
            shamt_q     <= '0;
            ctrl_q      <= '0;
            dest_q      <= '0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
        end else if (pipe.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            alu_a_q     <= rs_fwd;
            alu_b_q     <= dec_use_imm ? dec_imm : rt_fwd;
            store_q     <= rt_fwd;
            shamt_q     <= dec_shamt;
            ctrl_q      <= dec_ctrl;
            dest_q      <= dec_rd;
            rw_q        <= dec_rw;
            mr_q        <= dec_mr;
            mw_q        <= dec_mw;
            br_q        <= dec_br;
            ill_q       <= dec_ill;
        end else if (advance) begin
            // Nothing accepted (idle or load-use stall): issue a bubble.
            out_valid_q <= 1'b0;
        end
    end

    assign pipe.out_valid   = out_valid_q;
    assign pipe.alu_a       = alu_a_q;
    assign pipe.alu_b       = alu_b_q;
    assign pipe.alu_shamt   = shamt_q;
    assign pipe.alu_control = ctrl_q;
    assign pipe.store_data  = store_q;
    assign pipe.dest_rd     = dest_q;
    assign pipe.reg_write   = rw_q;
    assign pipe.mem_read    = mr_q;
    assign pipe.mem_write   = mw_q;
    assign pipe.branch      = br_q;
    assign pipe.illegal     = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, load-use stall,
// backpressure, flush, illegal opcodes and asynchronous reset.
module tb_id_ex_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    id_ex_stage_if pipe ();

    id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pipe  (pipe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pipe.flush = 1'b0;        pipe.in_valid = 1'b0;     pipe.instr = '0;
        pipe.rs_data = '0;        pipe.rt_data = '0;        pipe.ex_result = '0;
        pipe.exmem_wr = 1'b0;     pipe.exmem_rd = '0;       pipe.exmem_result = '0;
        pipe.memwb_wr = 1'b0;     pipe.memwb_rd = '0;       pipe.memwb_result = '0;
        pipe.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'b0, pipe.out_valid}, 32'd0);
        chk("rst_alu_a", pipe.alu_a, 32'd0);
        chk("rst_in_ready", {31'b0, pipe.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // add $3,$1,$2
        pipe.in_valid = 1'b1; pipe.instr = 32'h00221820;
        pipe.rs_data = 32'd5; pipe.rt_data = 32'd7;
        #1;
        chk("add_in_ready", {31'b0, pipe.in_ready}, 32'd1);
        tick();
        chk("add_ctrl", {29'b0, pipe.alu_control}, 32'd2);
        chk("add_a", pipe.alu_a, 32'd5);
        chk("add_b", pipe.alu_b, 32'd7);
        chk("add_rd", {27'b0, pipe.dest_rd}, 32'd3);
        chk("add_rw", {31'b0, pipe.reg_write}, 32'd1);
        chk("add_valid", {31'b0, pipe.out_valid}, 32'd1);

        // addi $1,$0,-1 : $0 reads zero despite stale rs_data
        pipe.instr = 32'h2001FFFF; pipe.rs_data = 32'h55;
        tick();
        chk("addi_a", pipe.alu_a, 32'd0);
        chk("addi_b", pipe.alu_b, 32'hFFFFFFFF);
        chk("addi_rd", {27'b0, pipe.dest_rd}, 32'd1);

        // andi $2,$1,0xFFFF : rs forwarded from EX
        pipe.instr = 32'h3022FFFF; pipe.rs_data = 32'h11; pipe.ex_result = 32'hFFFFFFFF;
        tick();
        chk("andi_a_fwd", pipe.alu_a, 32'hFFFFFFFF);
        chk("andi_b", pipe.alu_b, 32'h0000FFFF);
        chk("andi_ctrl", {29'b0, pipe.alu_control}, 32'd0);

        // lw $4,0($1)
        pipe.instr = 32'h8C240000; pipe.rs_data = 32'h100; pipe.ex_result = 32'h0;
        tick();
        chk("lw_a", pipe.alu_a, 32'h100);
        chk("lw_mr", {31'b0, pipe.mem_read}, 32'd1);
        chk("lw_rd", {27'b0, pipe.dest_rd}, 32'd4);

        // sub $5,$4,$2 : load-use stall, bubble, then forward from EX/MEM
        pipe.instr = 32'h00822822; pipe.rs_data = 32'h0; pipe.rt_data = 32'h22;
        #1;
        chk("lu_in_ready", {31'b0, pipe.in_ready}, 32'd0);
        tick();
        chk("lu_bubble", {31'b0, pipe.out_valid}, 32'd0);
        pipe.exmem_wr = 1'b1; pipe.exmem_rd = 5'd4; pipe.exmem_result = 32'h1234;
        #1;
        chk("lu_ready_again", {31'b0, pipe.in_ready}, 32'd1);
        tick();
        chk("sub_a_fwd", pipe.alu_a, 32'h1234);
        chk("sub_b", pipe.alu_b, 32'h22);
        chk("sub_ctrl", {29'b0, pipe.alu_control}, 32'd6);
        chk("sub_valid", {31'b0, pipe.out_valid}, 32'd1);
        pipe.exmem_wr = 1'b0;

        // sll $6,$7,31
        pipe.instr = 32'h000737C0; pipe.rs_data = 32'h0; pipe.rt_data = 32'h1;
        tick();
        chk("sll_shamt", {26'b0, pipe.alu_shamt}, 32'd31);
        chk("sll_ctrl", {29'b0, pipe.alu_control}, 32'd5);
        chk("sll_b", pipe.alu_b, 32'd1);

        // add $8,$9,$10 : EX/MEM beats MEM/WB on rs
        pipe.instr = 32'h012A4020; pipe.rs_data = 32'h9; pipe.rt_data = 32'h10;
        pipe.exmem_wr = 1'b1; pipe.exmem_rd = 5'd9; pipe.exmem_result = 32'hAAAA0000;
        pipe.memwb_wr = 1'b1; pipe.memwb_rd = 5'd9; pipe.memwb_result = 32'h0000BBBB;
        tick();
        chk("prio_a", pipe.alu_a, 32'hAAAA0000);
        chk("prio_b", pipe.alu_b, 32'h10);

        // MEM/WB alone on rt
        pipe.exmem_wr = 1'b0; pipe.memwb_rd = 5'd10;
        tick();
        chk("memwb_a_rf", pipe.alu_a, 32'h9);
        chk("memwb_b_fwd", pipe.alu_b, 32'h0000BBBB);
        pipe.memwb_wr = 1'b0;

        // Backpressure: 3 cycles held
        pipe.out_ready = 1'b0; pipe.instr = 32'h00221820;
        pipe.rs_data = 32'h77; pipe.rt_data = 32'h88;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'b0, pipe.in_ready}, 32'd0);
            tick();
            chk("bp_hold_a", pipe.alu_a, 32'h9);
            chk("bp_hold_valid", {31'b0, pipe.out_valid}, 32'd1);
        end

        // Flush with in_valid high drops the word
        pipe.out_ready = 1'b1; pipe.flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, pipe.in_ready}, 32'd1);
        tick();
        chk("flush_valid", {31'b0, pipe.out_valid}, 32'd0);
        pipe.flush = 1'b0; pipe.in_valid = 1'b0;
        tick();
        chk("flush_dropped", {31'b0, pipe.out_valid}, 32'd0);

        // sw $2,4($1)
        pipe.in_valid = 1'b1; pipe.instr = 32'hAC220004;
        pipe.rs_data = 32'h40; pipe.rt_data = 32'h77;
        tick();
        chk("sw_b", pipe.alu_b, 32'd4);
        chk("sw_store", pipe.store_data, 32'h77);
        chk("sw_mw", {31'b0, pipe.mem_write}, 32'd1);
        chk("sw_rw", {31'b0, pipe.reg_write}, 32'd0);

        // beq $1,$2
        pipe.instr = 32'h10220003;
        tick();
        chk("beq_ctrl", {29'b0, pipe.alu_control}, 32'd6);
        chk("beq_br", {31'b0, pipe.branch}, 32'd1);
        chk("beq_b", pipe.alu_b, 32'h77);

        // Illegal opcode 0x3F
        pipe.instr = 32'hFC221800;
        tick();
        chk("ill_flag", {31'b0, pipe.illegal}, 32'd1);
        chk("ill_rw", {31'b0, pipe.reg_write}, 32'd0);
        chk("ill_mw", {31'b0, pipe.mem_write}, 32'd0);
        chk("ill_ctrl", {29'b0, pipe.alu_control}, 32'd2);
        chk("ill_valid", {31'b0, pipe.out_valid}, 32'd1);

        // Reset pulsed mid-hold clears outputs immediately
        pipe.in_valid = 1'b0; pipe.out_ready = 1'b0;
        tick();
        chk("hold_ill", {31'b0, pipe.illegal}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, pipe.out_valid}, 32'd0);
        chk("arst_ill", {31'b0, pipe.illegal}, 32'd0);
        chk("arst_a", pipe.alu_a, 32'd0);
        chk("arst_b", pipe.alu_b, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", {31'b0, pipe.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue register stage directly upstream of the 32-bit ALU.
- Each cycle it decodes one instruction word into the ALU's 3-bit control code, 6-bit shift amount and operands A/B, resolving data hazards by forwarding.
- Issue stalls for one cycle on a load-use hazard.
- Outputs are registered and drive the ALU combinationally in the EX cycle; valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- FWD_EN, 1, 1 enables forwarding; 0 takes rs/rt only from the register file.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard held and incoming instruction (branch taken).
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage accepts instruction this cycle.
- instr  in  32  MIPS-format instruction.
- rs_data  in  32  register-file read port 1 (instr[25:21]).
- rt_data  in  32  register-file read port 2 (instr[20:16]).
- ex_result  in  32  current ALU output (instruction held in this stage).
- exmem_wr, exmem_rd, exmem_result  in  1/5/32  EX/MEM writeback candidate.
- memwb_wr, memwb_rd, memwb_result  in  1/5/32  MEM/WB writeback candidate.
- out_valid  out  1  issued instruction valid.
- out_ready  in  1  EX accepts issued instruction.
- alu_a, alu_b  out  32  ALU operands.
- alu_shamt  out  6  {1'b0, instr[10:6]}.
- alu_control  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NAND, 101 SLL (b<<shamt), 110 SUB, 111 SLT.
- store_data  out  32  forwarded rt value for sw.
- dest_rd  out  5  destination register.
- reg_write, mem_read, mem_write, branch, illegal  out  1 each  control flags.

Behaviour:
- Reset: all outputs and internal registers 0, including out_valid. in_ready is combinational and is 1 after reset.
- advance = !out_valid | out_ready. load_use = out_valid & mem_read & dest_rd != 0 & dest_rd matches the incoming rs or rt field.
- in_ready = advance & !load_use. flush overrides this: in_ready = 1.
- Latency: instruction accepted at edge N appears on the outputs after edge N, i.e. 1 cycle. Throughput is 1 instruction/cycle when there is no stall.
- Capture on in_valid & in_ready & !flush: decode the fields, latch the forwarded operands, set out_valid = 1.
- advance & (!in_valid | load_use): out_valid = 0 (bubble).
- !advance: hold all outputs stable.
- flush: out_valid = 0 next edge and the incoming word is dropped. flush wins over every other event.
- Forward priority for rs and rt:
  - EX: out_valid & reg_write & !mem_read & dest_rd match → ex_result.
  - else exmem_wr & exmem_rd match → exmem_result.
  - else memwb_wr & memwb_rd match → memwb_result.
  - else register file.
  - Register 0 is never forwarded and always reads 0.
- R-type (opcode 0), funct decode:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NAND, 0x2A SLT, 0x00 SLL.
  - alu_a = rs, alu_b = rt, dest_rd = instr[15:11], reg_write = 1.
  - For SLL, alu_b = rt and alu_a is don't-care (driven as rs).
- I-type:
  - addi 0x08 ADD, slti 0x0A SLT: sign-extended immediate.
  - andi 0x0C, ori 0x0D, xori 0x0E: zero-extended immediate.
  - alu_b = immediate, dest_rd = rt, reg_write = 1.
- lw 0x23: ADD with sign-extended immediate, mem_read = 1, reg_write = 1, dest_rd = rt.
- sw 0x2B: ADD with sign-extended immediate, mem_write = 1, store_data = forwarded rt.
- beq 0x04: SUB rs−rt, branch = 1.
- Any other opcode or funct: illegal = 1, alu_control = ADD, every write and memory flag = 0, out_valid still 1.
- dest_rd = 0 forces reg_write = 0.
- Reset asserted mid-stall or mid-hold: outputs clear immediately (asynchronous); no pending instruction survives.

Decomposition:
- Shared package (cpu_pkg):
  - ALU control code constants.
  - Opcode and funct constants.
  - XLEN.
- Sub-module id_decode: purely combinational instr → alu_control, immediate select/extend, control flags, dest_rd, illegal. It is reused by the single-cycle datapath.
- Forwarding muxes and the handshake stay in id_ex_stage.

Test Plan:
- Reset, then `add $3,$1,$2` with rs_data = 5, rt_data = 7, no forwarding → next cycle alu_control = 010, alu_a = 5, alu_b = 7, dest_rd = 3, reg_write = 1, out_valid = 1.
- `addi $1,$0,-1` then `andi $2,$1,0xFFFF`:
  - addi → alu_b = 0xFFFFFFFF.
  - andi, with ex_result = 0xFFFFFFFF → alu_a forwarded = 0xFFFFFFFF, alu_b = 0x0000FFFF, alu_control = 000.
- `lw $4,0($1)` then `sub $5,$4,$2`:
  - in_ready = 0 for one cycle, followed by a bubble with out_valid = 0.
  - Then sub issues with alu_a = exmem_result (e.g. 0x1234), alu_control = 110.
- `sll $6,$7,31` with rt_data = 1 → alu_shamt = 6'd31, alu_control = 101, alu_b = 1. Also check priority: when exmem and memwb both match rs, exmem_result is taken.
- Backpressure and flush:
  - out_ready = 0 for 3 cycles → outputs stable and in_ready = 0.
  - flush while in_valid = 1 → out_valid = 0 next cycle and the word is dropped.
- Opcode 0x3F → illegal = 1, reg_write = mem_write = 0. rst_n pulsed low mid-hold → all outputs 0 immediately.
